// File: rtl/prbs31_checker.sv
// PRBS31 (x^31 + x^28 + 1) receive checker.
// Shifts received bits into a 31-bit register until it holds a full seed,
// verifies LOCK_CNT consecutive correct predictions, and then flywheels on
// its own predictions while counting bit errors. Lock is dropped when
// LOSS_ERR errors land inside one LOSS_WIN-bit window.
module prbs31_checker #(
  parameter int unsigned LOCK_CNT = 64,
  parameter int unsigned LOSS_ERR = 8,
  parameter int unsigned LOSS_WIN = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        din,
  input  logic        din_valid,
  input  logic        clr_cnt,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_cnt,
  output logic [1:0]  state
);

  localparam int unsigned MW  = $clog2(LOCK_CNT + 1);
  localparam int unsigned WBW = (LOSS_WIN > 1) ? $clog2(LOSS_WIN) : 1;
  localparam int unsigned WEW = (LOSS_ERR > 1) ? $clog2(LOSS_ERR) : 1;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2,
    UNUSED = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [30:0]      s_q, s_d;
  logic [4:0]       srch_q, srch_d;
  logic [MW-1:0]    match_q, match_d;
  logic [WBW-1:0]   wbits_q, wbits_d;
  logic [WEW-1:0]   werrs_q, werrs_d;
  logic             err_pulse_q, err_inc;
  logic [15:0]      err_cnt_q, err_cnt_d;
  logic             pred, bit_err;

  assign pred    = s_q[30] ^ s_q[27];
  assign bit_err = din ^ pred;

  // Next-state, shift register, counters and error accounting
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    srch_d    = srch_q;
    match_d   = match_q;
    wbits_d   = wbits_q;
    werrs_d   = werrs_q;
    err_inc   = 1'b0;
    err_cnt_d = err_cnt_q;

    case (state_q)
      SEARCH: begin
        if (din_valid) begin
          s_d = {s_q[29:0], din};
          if (srch_q == 5'd30) begin
            state_d = VERIFY;
            srch_d  = '0;
            match_d = '0;
          end else begin
            srch_d = srch_q + 1'b1;
          end
        end
      end
      VERIFY: begin
        if (din_valid) begin
          s_d = {s_q[29:0], din};
          // An all-zero register predicts zeros forever, so it never counts
          if (!bit_err && (s_q != '0)) begin
            if (match_q == MW'(LOCK_CNT - 1)) begin
              state_d = LOCKED;
              match_d = '0;
              wbits_d = '0;
              werrs_d = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            match_d = '0;
          end
        end
      end
      LOCKED: begin
        if (din_valid) begin
          s_d     = {s_q[29:0], pred};
          err_inc = bit_err;
          if (bit_err && (werrs_q == WEW'(LOSS_ERR - 1))) begin
            state_d = SEARCH;
            srch_d  = '0;
            match_d = '0;
            wbits_d = '0;
            werrs_d = '0;
          end else if (wbits_q == WBW'(LOSS_WIN - 1)) begin
            // The bit closing a window is accounted before both counters restart
            wbits_d = '0;
            werrs_d = '0;
          end else begin
            wbits_d = wbits_q + 1'b1;
            werrs_d = werrs_q + WEW'(bit_err);
          end
        end
      end
      default: state_d = SEARCH;
    endcase

    if (clr_cnt)
      err_cnt_d = '0;
    else if (err_inc && (err_cnt_q != 16'hFFFF))
      err_cnt_d = err_cnt_q + 1'b1;
  end

  // State and output registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= SEARCH;
      s_q         <= '0;
      srch_q      <= '0;
      match_q     <= '0;
      wbits_q     <= '0;
      werrs_q     <= '0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      srch_q      <= srch_d;
      match_q     <= match_d;
      wbits_q     <= wbits_d;
      werrs_q     <= werrs_d;
      err_pulse_q <= err_inc;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign state     = state_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_prbs31_checker.sv
// Self-checking bench for prbs31_checker: queue-based reference model,
// directed lock/error/loss scenarios, a vector table and random traffic.
module tb_prbs31_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1, din = 1'b0, din_valid = 1'b0, clr_cnt = 1'b0;
  logic        locked, err_pulse;
  logic [15:0] err_cnt;
  logic [1:0]  state;

  logic        rst2 = 1'b1, din2 = 1'b0, valid2 = 1'b0, clr2 = 1'b0;
  logic        locked2, err_pulse2;
  logic [15:0] err_cnt2;
  logic [1:0]  state2;

  always #5 clk = ~clk;

  prbs31_checker #(.LOCK_CNT(64), .LOSS_ERR(8), .LOSS_WIN(128)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .state(state)
  );

  // Second instance whose loss criteria are out of reach, for saturation
  prbs31_checker #(.LOCK_CNT(64), .LOSS_ERR(100000), .LOSS_WIN(200000)) dut2 (
    .clk(clk), .rst_n(rst2), .din(din2), .din_valid(valid2), .clr_cnt(clr2),
    .locked(locked2), .err_pulse(err_pulse2), .err_cnt(err_cnt2), .state(state2)
  );

  int total = 0;
  int bad = 0;
  int pulse_seen = 0;
  int stepno = 0;

  // Transmit-side generator
  logic [30:0] g, g2;

  function automatic bit prbs_bit(input logic [30:0] x);
    return x[30] ^ x[27];
  endfunction

  function bit gen_next();
    bit b;
    b = prbs_bit(g);
    g = {g[29:0], b};
    return b;
  endfunction

  // Reference model: history of the last 31 bits shifted in, plus 1-based counts
  int m_mode, m_srch, m_match, m_wb, m_we, m_cnt;
  bit m_pulse;
  bit hist[$];

  task automatic model_step(input bit d, input bit v, input bit c, input bit r);
    bit p, nz, e;
    if (r) begin
      m_mode = 0; m_srch = 0; m_match = 0; m_wb = 0; m_we = 0; m_cnt = 0; m_pulse = 0;
      hist = {};
      repeat (31) hist.push_back(1'b0);
      return;
    end
    e = 0;
    if (v) begin
      p  = hist[0] ^ hist[3];
      nz = 0;
      foreach (hist[k]) if (hist[k]) nz = 1;
      case (m_mode)
        0: begin
          hist.push_back(d);
          m_srch++;
          if (m_srch == 31) begin m_mode = 1; m_srch = 0; m_match = 0; end
        end
        1: begin
          hist.push_back(d);
          if (d == p && nz) begin
            m_match++;
            if (m_match == 64) begin m_mode = 2; m_match = 0; m_wb = 0; m_we = 0; end
          end else m_match = 0;
        end
        default: begin
          hist.push_back(p);
          e = (d != p);
          if (e) m_we++;
          m_wb++;
          if (e && m_we == 8) begin
            m_mode = 0; m_srch = 0; m_match = 0; m_wb = 0; m_we = 0;
          end else if (m_wb == 128) begin
            m_wb = 0; m_we = 0;
          end
        end
      endcase
      void'(hist.pop_front());
    end
    m_pulse = e;
    if (c) m_cnt = 0;
    else if (e && m_cnt < 65535) m_cnt++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Drive one cycle, advance the model, compare every output against it
  task automatic step(input bit d, input bit v, input bit c, input bit r);
    din = d; din_valid = v; clr_cnt = c; rst_n = r;
    @(posedge clk);
    model_step(d, v, c, r);
    #1;
    stepno++;
    if (err_pulse) pulse_seen++;
    total++;
    if (state != 2'(m_mode) || locked != (m_mode == 2) || err_pulse != m_pulse ||
        err_cnt != 16'(m_cnt)) begin
      bad++;
      $display("FAIL step%0d: state=%0d locked=%0b pulse=%0b cnt=%0d, want %0d %0b %0b %0d",
               stepno, state, locked, err_pulse, err_cnt, m_mode, m_mode == 2, m_pulse, m_cnt);
    end
  endtask

  task automatic feed(input bit flip, input bit v, input bit c, input bit r);
    bit d;
    d = v ? (gen_next() ^ flip) : 1'($urandom_range(0, 1));
    step(d, v, c, r);
  endtask

  task automatic wait_lock(input bit randv, output int nvalid);
    int cnt;
    bit v;
    cnt = 0;
    nvalid = -1;
    for (int i = 0; i < 2000; i++) begin
      v = randv ? 1'($urandom_range(0, 1)) : 1'b1;
      feed(0, v, 0, 0);
      if (v) cnt++;
      if (locked) begin
        nvalid = cnt;
        break;
      end
    end
  endtask

  task automatic reset_dut();
    feed(0, 0, 0, 1);
    feed(0, 0, 0, 1);
    g = 31'h1;
  endtask

  typedef struct {
    bit v, flip, clr, rst;
    int st;
    bit lk, pl;
    int cnt;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int n, err_at, prev;
    bit ever_locked;
    bit v, f, c, r;

    tbl[0] = '{1, 0, 0, 0, 2, 1, 0, 0};
    tbl[1] = '{1, 1, 0, 0, 2, 1, 1, 1};
    tbl[2] = '{0, 1, 0, 0, 2, 1, 0, 1};
    tbl[3] = '{1, 0, 1, 0, 2, 1, 0, 0};
    tbl[4] = '{1, 1, 0, 0, 2, 1, 1, 1};
    tbl[5] = '{1, 1, 1, 0, 2, 1, 1, 0};
    tbl[6] = '{1, 0, 0, 1, 0, 0, 0, 0};
    tbl[7] = '{1, 0, 0, 0, 0, 0, 0, 0};

    // Reset state
    reset_dut();
    chk("reset_state", {28'd0, state, locked, err_pulse}, 0);
    chk("reset_cnt", err_cnt, 0);

    // Clean continuous stream locks after 31 + 64 valid bits
    wait_lock(0, n);
    chk("lock_clean", n, 95);
    chk("lock_clean_cnt", err_cnt, 0);

    // Three isolated errors while locked
    pulse_seen = 0;
    repeat (20) feed(0, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      feed(1, 1, 0, 0);
      repeat (20) feed(0, 1, 0, 0);
    end
    chk("iso_pulses", pulse_seen, 3);
    chk("iso_cnt", err_cnt, 3);
    chk("iso_locked", locked, 1);

    // Eight errors in one window drop lock on the eighth, then relock
    reset_dut();
    wait_lock(0, n);
    chk("relock_pre", n, 95);
    err_at = 0;
    pulse_seen = 0;
    for (int k = 1; k <= 8; k++) begin
      feed(1, 1, 0, 0);
      if (state == 2'd0 && err_at == 0) err_at = k;
      if (k < 8) feed(0, 1, 0, 0);
    end
    chk("loss_at", err_at, 8);
    chk("loss_cnt", err_cnt, 8);
    chk("loss_pulses", pulse_seen, 8);
    wait_lock(0, n);
    chk("relock", n, 95);

    // Constant-zero input never locks
    reset_dut();
    ever_locked = 0;
    for (int i = 0; i < 1000; i++) begin
      step(0, 1, 0, 0);
      if (locked || state == 2'd2) ever_locked = 1;
    end
    chk("zeros_no_lock", ever_locked, 0);

    // Gapped valid still locks after 95 valid bits; clr beats a coincident error
    reset_dut();
    wait_lock(1, n);
    chk("lock_gapped", n, 95);
    feed(1, 1, 0, 0);
    chk("err_before_clr", err_cnt, 1);
    feed(1, 1, 1, 0);
    chk("clr_vs_err_cnt", err_cnt, 0);
    chk("clr_vs_err_pulse", err_pulse, 1);

    // Vector table starting from a fresh lock
    reset_dut();
    wait_lock(0, n);
    for (int i = 0; i < 8; i++) begin
      feed(tbl[i].flip, tbl[i].v, tbl[i].clr, tbl[i].rst);
      chk($sformatf("tbl%0d", i), {12'd0, err_cnt, err_pulse, locked, state},
          {12'd0, 16'(tbl[i].cnt), tbl[i].pl, tbl[i].lk, 2'(tbl[i].st)});
    end

    // Random traffic against the model
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 15) == 0);
      c = ($urandom_range(0, 63) == 0);
      r = ($urandom_range(0, 1499) == 0);
      if (r) g = 31'h1;
      feed(f, v, c, r);
    end
    din_valid = 0; clr_cnt = 0;

    // Saturation on the second instance: every bit inverted once locked
    rst2 = 1;
    @(posedge clk); #1;
    rst2 = 0;
    g2 = 31'h1;
    for (int i = 0; i < 95; i++) begin
      din2 = prbs_bit(g2);
      g2 = {g2[29:0], din2};
      valid2 = 1;
      @(posedge clk); #1;
    end
    chk("sat_lock", locked2, 1);
    prev = 0;
    for (int i = 1; i <= 65540; i++) begin
      din2 = ~prbs_bit(g2);
      g2 = {g2[29:0], ~din2};
      @(posedge clk); #1;
      if (i == 10) chk("sat_cnt10", err_cnt2, 10);
      if (i == 65534) chk("sat_fffe", err_cnt2, 16'hFFFE);
      if (i == 65535) chk("sat_ffff", err_cnt2, 16'hFFFF);
    end
    chk("sat_hold", err_cnt2, 16'hFFFF);
    chk("sat_locked", locked2, 1);
    // Reset in the middle of LOCKED clears everything next cycle
    rst2 = 1;
    @(posedge clk); #1;
    chk("sat_reset", {12'd0, err_cnt2, err_pulse2, locked2, state2}, prev);
    rst2 = 0; valid2 = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prbs31_checker.md
PRBS31_CHECKER -- requirements
Module: prbs31_checker

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 64: consecutive correct predictions needed to declare lock.
REQ-002 SHALL have parameter LOSS_ERR, default 8: errors within one window that force loss of lock.
REQ-003 SHALL have parameter LOSS_WIN, default 128: loss-of-lock window length in valid bits.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1: one clock; reset is synchronous and active-high (rst_n=1 resets).
REQ-006 SHALL have port din, input, 1: received serial bit, PRBS31 x^31+x^28+1 as produced by the team's generator.
REQ-007 SHALL have port din_valid, input, 1: din qualifier; no state advances while low.
REQ-008 SHALL have port clr_cnt, input, 1: synchronous clear of err_cnt only.
REQ-009 SHALL have port locked, output, 1: high in LOCKED state.
REQ-010 SHALL have port err_pulse, output, 1: one-cycle pulse per bit error detected while LOCKED.
REQ-011 SHALL have port err_cnt, output, 16: saturating bit-error count.
REQ-012 SHALL have port state, output, 2: SEARCH=0, VERIFY=1, LOCKED=2; 3 unused.

Function
REQ-013 SHALL keep a 31-bit register s; predicted bit p = s[30] XOR s[27].
REQ-014 SHALL, on every valid bit, shift s left: s <= {s[29:0], b}, with b = din in SEARCH/VERIFY and b = p in LOCKED.
REQ-015 SHALL, in SEARCH, count valid bits; after 31 valid bits go to VERIFY with match count 0.
REQ-016 SHALL, in VERIFY, increment the match count when din == p and s != 0; otherwise clear it to 0 and stay in VERIFY.
REQ-017 SHALL go VERIFY -> LOCKED on the valid bit that brings the match count to LOCK_CNT.
REQ-018 SHALL treat an all-zero s as a mismatch in VERIFY, so a constant-0 input never locks.
REQ-019 SHALL, in LOCKED, flag an error when din != p on a valid bit.
REQ-020 SHALL register outputs: err_pulse and err_cnt update one cycle after the erroneous valid bit is sampled; locked/state follow registered state directly.
REQ-021 SHALL increment err_cnt per error, saturating at 16'hFFFF with no wrap.
REQ-022 SHALL give clr_cnt priority over a simultaneous increment: err_cnt becomes 0 and that error is not counted.
REQ-023 SHALL count valid bits and errors in LOCKED per window of LOSS_WIN valid bits, restarting both counters at each window boundary.
REQ-024 SHALL go LOCKED -> SEARCH on the error that brings the window error count to LOSS_ERR, clearing the search count, match count and window counters.
REQ-025 SHALL count the error that triggers loss of lock in err_cnt and pulse err_pulse for it.
REQ-026 SHALL hold all state, counters and err_cnt while din_valid=0; err_pulse is 0 in such cycles.
REQ-027 SHALL return an unused state encoding to SEARCH on the next clock.

Reset
REQ-028 SHALL, with rst_n=1 at a rising edge, set state=SEARCH, s=0, all counters=0, locked=0, err_pulse=0, err_cnt=0.
REQ-029 SHALL give rst_n priority over din_valid and clr_cnt, and abort any state mid-operation, including LOCKED.

Verification
REQ-030 Bench SHALL: reset, feed clean PRBS31 seeded 31'h1 continuously valid -> locked rises after 31+64=95 valid bits, err_cnt stays 0.
REQ-031 Bench SHALL: once locked, invert 3 isolated bits -> exactly 3 err_pulse cycles, err_cnt=3, locked stays 1.
REQ-032 Bench SHALL: once locked, invert 8 bits within 128 -> return to SEARCH on the 8th error, err_cnt=8, then relock after 95 further clean bits.
REQ-033 Bench SHALL: feed constant 0 for 1000 valid bits -> never leaves SEARCH/VERIFY, locked=0.
REQ-034 Bench SHALL: toggle din_valid randomly (50%) on a clean stream -> lock after 95 valid bits; an error coinciding with clr_cnt -> err_cnt=0.
REQ-035 Bench SHALL: force err_cnt near saturation (65535 errors, or via parameter override) -> err_cnt holds at FFFF; rst_n mid-LOCKED -> all outputs 0 next cycle.
